// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard unit and its mul/div scoreboard.
//   FWD_RF / FWD_W / FWD_M : execute-stage forward select encodings
//   sb_state_e             : mul/div scoreboard state
//   MD_CNT_W               : latency counter width (covers MD_LAT up to 15)
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
   localparam logic [1:0] FWD_W  = 2'b01;   // operand from writeback stage
   localparam logic [1:0] FWD_M  = 2'b10;   // operand from memory stage

   localparam int unsigned MD_CNT_W = 4;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_BUSY = 1'b1
   } sb_state_e;

endpackage : hazard_pkg

// File: rtl/md_scoreboard.sv
// -----------------------------------------------------------------------------
// md_scoreboard
// Tracks a single in-flight multi-cycle mul/div operation.
// A launch in cycle t keeps md_busy_o high for cycles t+1..t+MD_LAT and pulses
// md_done_o in cycle t+MD_LAT. A launch in the done cycle is a legal
// back-to-back issue; a launch in any other busy cycle is ignored and sets the
// sticky md_err_o.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   md_start_i    : execute-stage instruction launches a mul/div
//   md_wr_reg_i   : destination register of the launching instruction
//   md_busy_o     : operation in flight
//   md_done_o     : one-cycle result-valid pulse
//   md_dest_o     : destination register of the tracked operation
//   md_err_o      : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              md_start_i,
   input  logic [REG_AW-1:0] md_wr_reg_i,
   output logic              md_busy_o,
   output logic              md_done_o,
   output logic [REG_AW-1:0] md_dest_o,
   output logic              md_err_o
);

   if (MD_LAT == 0 || MD_LAT > 15) begin : g_bad_md_lat
      $error("md_scoreboard: MD_LAT must be in 1..15");
   end

   localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LAT - 1);

   sb_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic [REG_AW-1:0]   dest_q, dest_d;
   logic                err_q, err_d;
   logic                done_raw;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      dest_d   = dest_q;
      err_d    = err_q;
      done_raw = (state_q == SB_BUSY) && (cnt_q == '0);

      case (state_q)
         SB_IDLE: begin
            if (md_start_i) begin
               state_d = SB_BUSY;
               cnt_d   = CNT_LOAD;
               dest_d  = md_wr_reg_i;
            end
         end
         SB_BUSY: begin
            if (done_raw) begin
               // The result retires this cycle, so a new launch is a clean
               // back-to-back issue rather than a collision.
               if (md_start_i) begin
                  cnt_d  = CNT_LOAD;
                  dest_d = md_wr_reg_i;
               end else begin
                  state_d = SB_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (md_start_i) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values; the reset is synchronous and clears all state,
      // abandoning any operation in flight.
      if (!rst_n) begin
         state_q <= SB_IDLE;
         cnt_q   <= '0;
         dest_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
         err_q   <= err_d;
      end
   end

   assign md_busy_o = (state_q == SB_BUSY);
   // Suppress the result pulse in a reset cycle: an abandoned operation
   // must never report completion.
   assign md_done_o = done_raw & rst_n;
   assign md_dest_o = dest_q;
   assign md_err_o  = err_q;

endmodule : md_scoreboard

// File: rtl/hazard_sb.sv
// -----------------------------------------------------------------------------
// hazard_sb
// Hazard unit for a 5-stage pipeline with a multi-cycle mul/div scoreboard.
// Computes execute/decode forwarding selects and the combined stall/flush
// (load-use, branch-compare and mul/div hazards).
// Optional feature (macro HAZARD_SB_PERF_EN): three saturating CNT_W-bit
// counters of cycles in which each stall term is high.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   BranchD, MdOpD                   : decode instr is branch / mul-div
//   RsD, RtD, RsE, RtE               : source registers
//   WriteRegE/M/W                    : destination registers per stage
//   RegWriteE/M/W, MemToRegE/M       : stage controls
//   MdStartE                         : execute instr launches mul/div
//   StallF, StallD, FlushE           : pipeline control
//   ForwardAD, ForwardBD             : decode-compare forward from M
//   ForwardAE, ForwardBE             : execute forward select (RF / W / M)
//   MdBusy, MdDone, MdDest, MdErr    : scoreboard status
//   LwStallCnt, BrStallCnt, MdStallCnt (HAZARD_SB_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_sb
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              BranchD,
   input  logic              MdOpD,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemToRegE,
   input  logic              MemToRegM,
   input  logic              MdStartE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushE,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdBusy,
   output logic              MdDone,
   output logic [REG_AW-1:0] MdDest,
`ifdef HAZARD_SB_PERF_EN
   output logic [CNT_W-1:0]  LwStallCnt,
   output logic [CNT_W-1:0]  BrStallCnt,
   output logic [CNT_W-1:0]  MdStallCnt,
`endif
   output logic              MdErr
);

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("hazard_sb: CNT_W must be at least 1");
   end

   logic lw_stall;
   logic br_stall;
   logic md_stall;

   // ---------------------------------------------------------------- scoreboard
   md_scoreboard #(
      .REG_AW (REG_AW),
      .MD_LAT (MD_LAT)
   ) u_md_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .md_start_i  (MdStartE),
      .md_wr_reg_i (WriteRegE),
      .md_busy_o   (MdBusy),
      .md_done_o   (MdDone),
      .md_dest_o   (MdDest),
      .md_err_o    (MdErr)
   );

   // ---------------------------------------------------------------- forwarding
   // Register 0 is hard-wired to zero and never forwarded. The M stage holds
   // the younger result, so it wins over W.
   function automatic logic [1:0] fwd_sel_e(input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != '0 && src == WriteRegM && RegWriteM) begin
         sel = FWD_M;
      end else if (src != '0 && src == WriteRegW && RegWriteW) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

   always_comb begin
      ForwardAE = fwd_sel_e(RsE);
      ForwardBE = fwd_sel_e(RtE);
      ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
      ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
   end

   // ---------------------------------------------------------------- stalls
   always_comb begin
      lw_stall = MemToRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

      // A branch compares in decode, so it must wait for an ALU result still
      // in E, or for a load result still in M (too late to forward).
      br_stall = BranchD &&
                 ((RegWriteE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                  (MemToRegM && (WriteRegM != '0) &&
                   ((WriteRegM == RsD) || (WriteRegM == RtD))));

      // A second mul/div must wait for the unit; any reader of the pending
      // destination must wait for its result.
      md_stall = MdBusy &&
                 (MdOpD || ((MdDest != '0) && ((MdDest == RsD) || (MdDest == RtD))));

      StallF = lw_stall | br_stall | md_stall;
      StallD = StallF;
      FlushE = StallF;
   end

   // ---------------------------------------------------------------- perf counters
`ifdef HAZARD_SB_PERF_EN
   logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      lw_cnt_d = lw_cnt_q;
      br_cnt_d = br_cnt_q;
      md_cnt_d = md_cnt_q;
      if (lw_stall && (lw_cnt_q != '1)) lw_cnt_d = lw_cnt_q + 1'b1;
      if (br_stall && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
      if (md_stall && (md_cnt_q != '1)) md_cnt_d = md_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lw_cnt_q <= '0;
         br_cnt_q <= '0;
         md_cnt_q <= '0;
      end else begin
         lw_cnt_q <= lw_cnt_d;
         br_cnt_q <= br_cnt_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   assign LwStallCnt = lw_cnt_q;
   assign BrStallCnt = br_cnt_q;
   assign MdStallCnt = md_cnt_q;
`else
`endif

endmodule : hazard_sb

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LAT, default 4, mul/div latency in cycles, legal 1..15.
REQ-003 SHALL have parameter CNT_W, default 16, perf-counter width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 BranchD, MdOpD  in  1  decode instr is branch / mul-div.
REQ-007 RsD, RtD, RsE, RtE  in  REG_AW  source registers.
REQ-008 WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination registers.
REQ-009 RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM  in  1  stage controls.
REQ-010 MdStartE  in  1  execute instr launches mul/div this cycle, dest = WriteRegE.
REQ-011 StallF, StallD, FlushE  out  1  pipeline control.
REQ-012 ForwardAD, ForwardBD  out  1  decode-compare forward from M.
REQ-013 ForwardAE, ForwardBE  out  2  execute forward select: 00 regfile, 01 W, 10 M.
REQ-014 MdBusy, MdDone  out  1  mul/div in flight / result-valid pulse.
REQ-015 MdDest  out  REG_AW  mul/div destination.
REQ-016 MdErr  out  1  sticky protocol-violation flag.

Function
REQ-017 ForwardAE SHALL be 10 if RsE!=0, RsE==WriteRegM, RegWriteM; else 01 if RsE!=0, RsE==WriteRegW, RegWriteW; else 00; ForwardBE identically on RtE.
REQ-018 ForwardAD/BD SHALL be 1 iff RsD/RtD !=0, equals WriteRegM, RegWriteM.
REQ-019 lwstall SHALL be MemToRegE and RtE!=0 and (RsD==RtE or RtD==RtE).
REQ-020 brstall SHALL be BranchD and ((RegWriteE, WriteRegE!=0, matches RsD/RtD) or (MemToRegM, WriteRegM!=0, matches RsD/RtD)).
REQ-021 mdstall SHALL be MdBusy and (MdOpD or (MdDest!=0 and MdDest equals RsD or RtD)).
REQ-022 StallF=StallD=FlushE SHALL equal lwstall|brstall|mdstall, combinational, same cycle.
REQ-023 Scoreboard FSM SHALL have states IDLE and BUSY; IDLE->BUSY on MdStartE, loading counter MD_LAT-1 and MdDest=WriteRegE.
REQ-024 In BUSY counter SHALL decrement each cycle; MdDone SHALL pulse one cycle when counter==0; BUSY->IDLE next edge.
REQ-025 MdStart at cycle t SHALL give MdBusy high t+1..t+MD_LAT, MdDone at t+MD_LAT.
REQ-026 MdStartE in BUSY SHALL not reload state and SHALL set MdErr until reset.
REQ-027 MdStartE in the MdDone cycle SHALL be accepted as back-to-back launch (stays BUSY, reloads), not an error.
REQ-028 All outputs SHALL be X-free when inputs are known; no X-checking logic.

Reset
REQ-029 rst_n low at edge SHALL force IDLE, counter 0, MdDest 0, MdErr 0, perf counters 0.
REQ-030 Reset mid-operation SHALL abandon in-flight mul/div with no MdDone pulse.
REQ-031 During reset combinational forward/stall outputs SHALL still follow inputs, MdBusy low.

Configuration
REQ-032 Macro HAZARD_SB_PERF_EN SHALL gate three CNT_W outputs LwStallCnt, BrStallCnt, MdStallCnt counting cycles each stall term is high, saturating at all-ones.
REQ-033 Without HAZARD_SB_PERF_EN these ports and counters SHALL be absent; other behaviour unchanged.

Structure
REQ-034 Package hazard_pkg SHALL hold forward-select constants FWD_RF/FWD_W/FWD_M and scoreboard state enum.
REQ-035 Sub-module md_scoreboard SHALL implement REQ-023..027; top holds forwarding, stall logic, counters.

Verification
REQ-036 RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10; RsE=0 same -> 00.
REQ-037 MemToRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 same cycle; RtE=0 -> 0.
REQ-038 MD_LAT=4, MdStartE at cycle 10, WriteRegE=8 -> MdBusy 11..14, MdDone at 14, RsD=8 stalls 11..14, free at 15.
REQ-039 MdStartE at 10 and 12 -> MdErr=1 from 13, MdDone still at 14.
REQ-040 rst_n low at cycle 12 of REQ-038 -> MdBusy 0 at 13, no MdDone, MdErr 0.
REQ-041 HAZARD_SB_PERF_EN, CNT_W=4, lwstall held 20 cycles -> LwStallCnt saturates at 15.
